// File: rtl/logic_probe_pkg.sv
// Shared types and constants for the multi-channel logic probe.
// Counter slot order inside a channel frame: low, high, z, lo_edges, hi_edges, pulse.
package logic_probe_pkg;

  typedef enum logic {
    MEASURE = 1'b0,
    HOLD    = 1'b1
  } state_e;

  localparam int COUNTERS_PER_CHANNEL = 6;

  localparam int IDX_LOW   = 0;
  localparam int IDX_HIGH  = 1;
  localparam int IDX_Z     = 2;
  localparam int IDX_LOE   = 3;
  localparam int IDX_HIE   = 4;
  localparam int IDX_PULSE = 5;

  function automatic int frame_width(input int ch, input int w);
    return ch * (COUNTERS_PER_CHANNEL * w + 2);
  endfunction

  function automatic int bits_for(input longint v);
    int b;
    b = 1;
    while ((longint'(1) << b) <= v) b++;
    return b;
  endfunction

endpackage

// File: rtl/probe_channel.sv
// One probe channel: input synchronizers, level latch,
// six saturating counters, overflow and invalid-input flags.
module probe_channel
  import logic_probe_pkg::*;
#(
  parameter int W = 28
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              comp_hi,
  input  logic                              comp_lo,
  input  logic                              en,
  input  logic                              clr,
  output logic [COUNTERS_PER_CHANNEL*W-1:0] counts,
  output logic                              ovf,
  output logic                              err
);

  localparam int N = COUNTERS_PER_CHANNEL;
  localparam logic [W-1:0] MAX = '1;

  logic         hi_meta_q, hi_sync_q, hi_prev_q;
  logic         lo_meta_q, lo_sync_q, lo_prev_q;
  logic         latch_q, latch_d;
  logic [W-1:0] cnt_q [N];
  logic [W-1:0] cnt_d [N];
  logic         ovf_q, ovf_d;
  logic         err_q, err_d;
  logic [N-1:0] inc;
  logic         hi, lo, sat;

  // Classify the synchronized levels and compute next counter state.
  always_comb begin
    hi = hi_sync_q;
    lo = lo_sync_q;
    latch_d = latch_q;
    if (hi && !lo) latch_d = 1'b1;
    else if (lo && !hi) latch_d = 1'b0;
    inc = '0;
    inc[IDX_LOW]   = en & lo & ~hi;
    inc[IDX_HIGH]  = en & hi & ~lo;
    inc[IDX_Z]     = en & ~hi & ~lo;
    inc[IDX_LOE]   = en & lo & ~lo_prev_q;
    inc[IDX_HIE]   = en & hi & ~hi_prev_q;
    inc[IDX_PULSE] = en & latch_d & ~latch_q;
    sat = 1'b0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr) cnt_d[i] = '0;
      else if (inc[i] && cnt_q[i] != MAX)
        cnt_d[i] = cnt_q[i] + 1'b1;
      if (cnt_d[i] == MAX) sat = 1'b1;
    end
    ovf_d = clr ? 1'b0 : (ovf_q | sat);
    err_d = clr ? 1'b0 : (err_q | (en & hi & lo));
  end

  // Synchronizers, edge history, latch, counters and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_meta_q <= 1'b0;
      hi_sync_q <= 1'b0;
      hi_prev_q <= 1'b0;
      lo_meta_q <= 1'b0;
      lo_sync_q <= 1'b0;
      lo_prev_q <= 1'b0;
      latch_q   <= 1'b0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      hi_meta_q <= comp_hi;
      hi_sync_q <= hi_meta_q;
      hi_prev_q <= hi_sync_q;
      lo_meta_q <= comp_lo;
      lo_sync_q <= lo_meta_q;
      lo_prev_q <= lo_sync_q;
      latch_q   <= latch_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Pack counters with the low counter in the top slot.
  always_comb begin
    counts = '0;
    for (int i = 0; i < N; i++)
      counts[(N-1-i)*W +: W] = cnt_q[i];
  end

  assign ovf = ovf_q;
  assign err = err_q;

endmodule

// File: rtl/logic_probe_multi.sv
// Multi-channel logic probe: gated measurement FSM,
// frame capture and serial readout on a synchronized shift clock.
module logic_probe_multi
  import logic_probe_pkg::*;
#(
  parameter int CHANNELS       = 2,
  parameter int COUNTERS_WIDTH = 28,
  parameter int DEFAULT_PERIOD = 2700000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       comp_hi,
  input  logic [CHANNELS-1:0]       comp_lo,
  input  logic [COUNTERS_WIDTH-1:0] period,
  input  logic                      shift_clk,
  output logic                      data,
  output logic                      interrupt,
  input  logic                      interrupt_clear
);

  localparam int W  = COUNTERS_WIDTH;
  localparam int CW = COUNTERS_PER_CHANNEL * W;
  localparam int FW = frame_width(CHANNELS, W);
  localparam int DW = bits_for(longint'(DEFAULT_PERIOD));
  localparam int GW = (DW > W) ? DW : W;

  state_e          state_q;
  logic [GW-1:0]   gate_q, gcnt_q, period_sel;
  logic            int_q;
  logic            en, clr, capture;
  logic            sh_meta_q, sh_sync_q, sh_prev_q, sh_edge;
  logic [FW-1:0]   frame_q, frame_d, frame_cap;
  logic [CW-1:0]   ch_counts [CHANNELS];
  logic [CHANNELS-1:0] ch_ovf, ch_err;

  // Gate selection and per-cycle control strobes.
  always_comb begin
    period_sel = (period == '0) ? GW'(DEFAULT_PERIOD) : GW'(period);
    clr     = interrupt_clear;
    en      = (state_q == MEASURE) && !interrupt_clear &&
              (gcnt_q != gate_q);
    capture = (state_q == MEASURE) && !interrupt_clear &&
              (gcnt_q == gate_q);
  end

  // Measurement FSM: count G cycles, then hold until cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MEASURE;
      int_q   <= 1'b0;
      gate_q  <= period_sel;
      gcnt_q  <= '0;
    end else begin
      unique case (state_q)
        MEASURE: begin
          if (interrupt_clear) begin
            gate_q <= period_sel;
            gcnt_q <= '0;
          end else if (capture) begin
            state_q <= HOLD;
            int_q   <= 1'b1;
          end else begin
            gcnt_q <= gcnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (interrupt_clear) begin
            state_q <= MEASURE;
            int_q   <= 1'b0;
            gate_q  <= period_sel;
            gcnt_q  <= '0;
          end
        end
      endcase
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    probe_channel #(.W(W)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .comp_hi (comp_hi[c]),
      .comp_lo (comp_lo[c]),
      .en      (en),
      .clr     (clr),
      .counts  (ch_counts[c]),
      .ovf     (ch_ovf[c]),
      .err     (ch_err[c])
    );
  end

  // Assemble the frame; a capture overrides a coincident shift.
  always_comb begin
    frame_cap = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      frame_cap[FW-1-c*CW -: CW]     = ch_counts[c];
      frame_cap[2*CHANNELS-1-c]      = ch_ovf[c];
      frame_cap[CHANNELS-1-c]        = ch_err[c];
    end
    sh_edge = sh_sync_q & ~sh_prev_q;
    if (capture) frame_d = frame_cap;
    else if (sh_edge) frame_d = {frame_q[FW-2:0], 1'b0};
    else frame_d = frame_q;
  end

  // Shift clock synchronizer and frame register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_meta_q <= 1'b0;
      sh_sync_q <= 1'b0;
      sh_prev_q <= 1'b0;
      frame_q   <= '0;
    end else begin
      sh_meta_q <= shift_clk;
      sh_sync_q <= sh_meta_q;
      sh_prev_q <= sh_sync_q;
      frame_q   <= frame_d;
    end
  end

  assign data      = frame_q[FW-1];
  assign interrupt = int_q;

endmodule

// File: tb/tb_logic_probe_multi.sv
// Directed bench for logic_probe_multi: table of gated scenarios
// plus hand sequences for reset-abort and readout corners.
module tb_logic_probe_multi;

  localparam int CH  = 2;
  localparam int W   = 4;
  localparam int DEF = 20;
  localparam int FW  = CH * (6 * W + 2);

  localparam int M_Z   = 0;
  localparam int M_HI  = 1;
  localparam int M_LO  = 2;
  localparam int M_TOG = 3;
  localparam int M_INV = 4;
  localparam int M_MIX = 5;

  typedef struct {
    string       name;
    int          per;
    int          g;
    int          m0;
    int          m1;
    bit          coin;
    bit          midclr;
    logic [23:0] e0;
    logic [23:0] e1;
    logic [1:0]  ovf;
    logic [1:0]  err;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] comp_hi, comp_lo;
  logic [W-1:0]  period;
  logic          shift_clk;
  logic          data;
  logic          interrupt;
  logic          interrupt_clear;

  int n_chk  = 0;
  int n_fail = 0;

  vec_t tbl [4];

  always #5 clk = ~clk;

  logic_probe_multi #(
    .CHANNELS       (CH),
    .COUNTERS_WIDTH (W),
    .DEFAULT_PERIOD (DEF)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .comp_hi         (comp_hi),
    .comp_lo         (comp_lo),
    .period          (period),
    .shift_clk       (shift_clk),
    .data            (data),
    .interrupt       (interrupt),
    .interrupt_clear (interrupt_clear)
  );

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input int per,
      input int g, input int m0, input int m1, input bit coin,
      input bit midclr, input logic [23:0] e0, input logic [23:0] e1,
      input logic [1:0] ovf, input logic [1:0] err);
    vec_t v;
    v.name = name; v.per = per; v.g = g; v.m0 = m0; v.m1 = m1;
    v.coin = coin; v.midclr = midclr;
    v.e0 = e0; v.e1 = e1; v.ovf = ovf; v.err = err;
    return v;
  endfunction

  // {hi, lo} seen by the channel on counted cycle k (k < 1: idle)
  function automatic logic [1:0] pat(input int m, input int k);
    if (k < 1) return 2'b00;
    case (m)
      M_HI:  return 2'b10;
      M_LO:  return 2'b01;
      M_TOG: return (((k - 1) / 2) % 2 == 0) ? 2'b01 : 2'b00;
      M_INV: return (k >= 4 && k <= 6) ? 2'b11 : 2'b10;
      M_MIX: begin
        case ((k - 1) / 2)
          0: return 2'b10;
          1: return 2'b00;
          2: return 2'b01;
          3: return 2'b00;
          4: return 2'b10;
          default: return 2'b01;
        endcase
      end
      default: return 2'b00;
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    comp_hi = '0;
    comp_lo = '0;
    shift_clk = 1'b0;
    interrupt_clear = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic shift_pulse();
    shift_clk = 1'b1;
    repeat (2) @(negedge clk);
    shift_clk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic read_frame(input bit midclr, output logic [FW-1:0] f);
    f = '0;
    for (int i = 0; i < FW; i++) begin
      if (midclr && i == FW - 2) begin
        interrupt_clear = 1'b1;
        @(negedge clk);
        interrupt_clear = 1'b0;
        @(negedge clk);
        check("int_after_clear", interrupt, 0);
      end
      f[FW-1-i] = data;
      shift_pulse();
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [FW-1:0] f;
    logic [1:0] p0, p1;
    period = W'(v.per);
    do_reset();
    for (int j = -3; j <= v.g; j++) begin
      p0 = pat(v.m0, j + 2);
      p1 = pat(v.m1, j + 2);
      comp_hi = {p1[1], p0[1]};
      comp_lo = {p1[0], p0[0]};
      interrupt_clear = (j == 0);
      shift_clk = v.coin && (j == v.g - 1);
      @(negedge clk);
    end
    interrupt_clear = 1'b0;
    shift_clk = 1'b0;
    check({v.name, "_int_early"}, interrupt, 0);
    @(negedge clk);
    check({v.name, "_int"}, interrupt, 1);
    read_frame(v.midclr, f);
    check({v.name, "_frame"}, f, {v.e0, v.e1, v.ovf, v.err});
    check({v.name, "_tail"}, data, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = mk("hold_hi", 10, 10, M_HI, M_Z, 0, 0,
                24'h0A0011, 24'h00A000, 2'b00, 2'b00);
    tbl[1] = mk("sat_lo", 0, DEF, M_LO, M_TOG, 0, 0,
                24'hF00100, 24'hA0A500, 2'b10, 2'b00);
    tbl[2] = mk("invalid", 12, 12, M_INV, M_MIX, 0, 1,
                24'h090111, 24'h444222, 2'b00, 2'b10);
    tbl[3] = mk("coincide", 15, 15, M_Z, M_HI, 1, 0,
                24'h00F000, 24'h0F0011, 2'b11, 2'b00);

    period = W'(10);
    do_reset();
    check("reset_int", interrupt, 0);
    check("reset_data", data, 0);

    for (int t = 0; t < 4; t++) run_vec(tbl[t]);

    begin : reset_abort
      logic [FW-1:0] f;
      period = W'(5);
      do_reset();
      comp_hi = 2'b11;
      interrupt_clear = 1'b1;
      @(negedge clk);
      interrupt_clear = 1'b0;
      repeat (10) @(negedge clk);
      check("short_int", interrupt, 1);
      repeat (5) shift_pulse();
      check("pre_clear_data", data, 1);
      interrupt_clear = 1'b1;
      @(negedge clk);
      interrupt_clear = 1'b0;
      @(negedge clk);
      check("hold_clear_int", interrupt, 0);
      check("clear_keeps_frame", data, 1);
      period = '0;
      do_reset();
      check("abort_int", interrupt, 0);
      check("abort_data", data, 0);
      repeat (DEF) @(negedge clk);
      check("def_int_early", interrupt, 0);
      @(negedge clk);
      check("def_int", interrupt, 1);
      read_frame(1'b0, f);
      check("def_frame", f, {24'h00F000, 24'h00F000, 2'b11, 2'b00});
      check("def_tail", data, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
